// File: rtl/dmem_arb_pkg.sv
// Shared constants for the DataMem port arbiter: memory op encodings, FSM state codes
// and the legality check applied to every accepted access.
package dmem_arb_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    // Misaligned accesses, unsigned stores and unused encodings never reach DataMem as a write.
    function automatic logic memop_illegal(input logic       we,
                                           input logic [2:0] memop,
                                           input logic [1:0] addr_lo);
        logic ill;
        ill = 1'b0;
        case (memop)
            MEMOP_B, MEMOP_BU: ill = 1'b0;
            MEMOP_H, MEMOP_HU: ill = addr_lo[0];
            MEMOP_W:           ill = (addr_lo != 2'b00);
            default:           ill = 1'b1;
        endcase
        if (we && memop[2]) begin
            ill = 1'b1;
        end
        return ill;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: a lone requester always wins; a tie goes to port 0 when fixed_prio
// is set, otherwise to the port that was not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |req;
        grant_id    = 1'b0;
        if (req == 2'b11) begin
            grant_id = fixed_prio ? 1'b0 : ~last_grant;
        end else if (req == 2'b10) begin
            grant_id = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single DataMem port between the CPU MEM stage (port 0) and the loader (port 1),
// running each access as a fixed IDLE -> ACCESS -> FINISH sequence followed by a one-cycle ack.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter bit CPU_PRIORITY = 1'b0,
    parameter int AW           = 18
) (
    input  logic          clk,
    input  logic          rstn,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [2:0]    p0_memop,
    input  logic [AW-1:0] p0_addr,
    input  logic [31:0]   p0_wdata,
    output logic          p0_ack,
    output logic [31:0]   p0_rdata,
    output logic          p0_err,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [2:0]    p1_memop,
    input  logic [AW-1:0] p1_addr,
    input  logic [31:0]   p1_wdata,
    output logic          p1_ack,
    output logic [31:0]   p1_rdata,
    output logic          p1_err,

    output logic          mem_we,
    output logic [2:0]    mem_memop,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_datain,
    input  logic [31:0]   mem_dataout,

    output logic          busy
);

    logic [1:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             cur_port_q, cur_port_d;
    logic             cap_we_q, cap_we_d;
    logic             illegal_q, illegal_d;
    logic             mem_we_q, mem_we_d;
    logic [2:0]       mem_memop_q, mem_memop_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [31:0]      mem_datain_q, mem_datain_d;
    logic [1:0]       ack_q, ack_d;
    logic [1:0]       err_q, err_d;
    logic [1:0][31:0] rdata_q, rdata_d;

    logic [1:0]       eligible;
    logic             grant_valid;
    logic             grant_id;
    logic             sel_we;
    logic [2:0]       sel_memop;
    logic [AW-1:0]    sel_addr;
    logic [31:0]      sel_wdata;

    // A port whose ack is showing is still holding req from the finished access; ignore it.
    assign eligible = {p1_req & ~ack_q[1], p0_req & ~ack_q[0]};

    rr_arb2 u_arb (
        .req         (eligible),
        .last_grant  (last_grant_q),
        .fixed_prio  (CPU_PRIORITY),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign sel_we    = grant_id ? p1_we    : p0_we;
    assign sel_memop = grant_id ? p1_memop : p0_memop;
    assign sel_addr  = grant_id ? p1_addr  : p0_addr;
    assign sel_wdata = grant_id ? p1_wdata : p0_wdata;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cur_port_d   = cur_port_q;
        cap_we_d     = cap_we_q;
        illegal_d    = illegal_q;
        mem_we_d     = 1'b0;
        mem_memop_d  = mem_memop_q;
        mem_addr_d   = mem_addr_q;
        mem_datain_d = mem_datain_q;
        ack_d        = 2'b00;
        err_d        = err_q;
        rdata_d      = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    mem_memop_d  = sel_memop;
                    mem_addr_d   = sel_addr;
                    mem_datain_d = sel_wdata;
                    cap_we_d     = sel_we;
                    illegal_d    = memop_illegal(sel_we, sel_memop, sel_addr[1:0]);
                    last_grant_d = grant_id;
                    cur_port_d   = grant_id;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // DataMem has now latched the address; the write strobe is registered for FINISH.
                mem_we_d = cap_we_q & ~illegal_q;
                state_d  = S_FINISH;
            end
            S_FINISH: begin
                ack_d[cur_port_q] = 1'b1;
                err_d[cur_port_q] = illegal_q;
                if (!cap_we_q) begin
                    rdata_d[cur_port_q] = illegal_q ? 32'h0 : mem_dataout;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            cur_port_q   <= 1'b0;
            cap_we_q     <= 1'b0;
            illegal_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_memop_q  <= MEMOP_W;
            mem_addr_q   <= '0;
            mem_datain_q <= 32'h0;
            ack_q        <= 2'b00;
            err_q        <= 2'b00;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_port_q   <= cur_port_d;
            cap_we_q     <= cap_we_d;
            illegal_q    <= illegal_d;
            mem_we_q     <= mem_we_d;
            mem_memop_q  <= mem_memop_d;
            mem_addr_q   <= mem_addr_d;
            mem_datain_q <= mem_datain_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_memop  = mem_memop_q;
    assign mem_addr   = mem_addr_q;
    assign mem_datain = mem_datain_q;
    assign busy       = (state_q != S_IDLE);

    assign p0_ack   = ack_q[0];
    assign p1_ack   = ack_q[1];
    assign p0_err   = err_q[0];
    assign p1_err   = err_q[1];
    assign p0_rdata = rdata_q[0];
    assign p1_rdata = rdata_q[1];

endmodule
